// File: rtl/seven_seg_display_if.sv
// seven_seg_display_if
//   Bundles the display-side signals of seven_seg_display.
//   value : 4-bit unsigned value to show (driven by the result path)
//   mode  : 0 = decimal on two digits, 1 = single hex digit
//   seg   : segment drive, active-low, {g,f,e,d,c,b,a}
//   an    : digit anodes, active-low, an[0] = rightmost digit
//   master: the producer of value/mode that observes seg/an
//   slave : the display driver itself
interface seven_seg_display_if;
  logic [3:0] value;
  logic       mode;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (output value, mode, input  seg, an);
  modport slave  (input  value, mode, output seg, an);
endinterface

// File: rtl/seven_seg_display.sv
// seven_seg_display
//   Multiplexed 4-digit common-anode seven-segment driver. A free-running
//   prescaler advances a 2-bit digit index once every REFRESH_DIV clocks;
//   each clock the output register loads the anode select and glyph of the
//   currently scanned digit (or all-off if that digit is blank).
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     dif   : slave modport carrying value/mode in and seg/an out
//   Parameters:
//     REFRESH_DIV : clocks per digit slot (>= 2)
//     CNT_W       : prescaler width, 2**CNT_W >= REFRESH_DIV

// Hex glyph decoder, active-low gfedcba.
module seven_seg_glyph (
  input  logic [3:0] code,
  output logic [6:0] glyph
);
  always_comb begin
    glyph = 7'h7F;
    unique case (code)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end
endmodule

// One digit position: decides whether the digit is lit and which glyph
// it carries, given the captured value/mode and the decimal split.
module seven_seg_digit #(
  parameter int unsigned IDX = 0
) (
  input  logic [3:0] vq,
  input  logic       mq,
  input  logic       tens,
  input  logic [3:0] ones,
  output logic       on,
  output logic [6:0] glyph
);
  logic [3:0] code;

  always_comb begin
    on   = 1'b0;
    code = 4'h0;
    if (IDX == 0) begin
      on   = 1'b1;
      code = mq ? vq : ones;
    end else if (IDX == 1) begin
      // Leading-zero suppression: the tens digit only ever shows '1'.
      on   = !mq && tens;
      code = 4'h1;
    end
  end

  seven_seg_glyph u_glyph (.code(code), .glyph(glyph));
endmodule

module seven_seg_display #(
  parameter int unsigned REFRESH_DIV = 16'd50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_display_if.slave   dif
);
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       vq;
  logic             mq;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  // Captured inputs; everything downstream works from these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq <= 4'h0;
      mq <= 1'b0;
    end else begin
      vq <= dif.value;
      mq <= dif.mode;
    end
  end

  // Prescaler and scan index; the index only moves on prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decimal split without a divider: value is at most 15.
  logic       tens;
  logic [3:0] ones;
  assign tens = (vq >= 4'd10);
  assign ones = tens ? (vq - 4'd10) : vq;

  logic [NUM_DIGITS-1:0]      dig_on;
  logic [NUM_DIGITS-1:0][6:0] dig_glyph;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    seven_seg_digit #(.IDX(d)) u_dig (
      .vq    (vq),
      .mq    (mq),
      .tens  (tens),
      .ones  (ones),
      .on    (dig_on[d]),
      .glyph (dig_glyph[d])
    );
  end

  // Output register: one-hot-low anode for a lit digit, all-off otherwise,
  // so at most one anode is ever active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else if (dig_on[idx]) begin
      seg_q <= dig_glyph[idx];
      an_q  <= ~(4'b0001 << idx);
    end else begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end
  end

  assign dif.seg = seg_q;
  assign dif.an  = an_q;
endmodule

// File: tb/tb_seven_seg_display.sv
module tb_seven_seg_display;
  localparam int DIV = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seven_seg_display_if dif();

  seven_seg_display #(.REFRESH_DIV(DIV), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  // Reference: what a digit slot shows for a given value/mode/position.
  function automatic logic [10:0] model(input logic [3:0] v, input logic m, input int pos);
    logic [10:0] r;
    r = {4'hF, 7'h7F};
    if (pos == 0) r = {4'b1110, m ? GLYPH[v] : GLYPH[v % 10]};
    else if (pos == 1 && !m && v >= 10) r = {4'b1101, GLYPH[1]};
    return r;
  endfunction

  // Model state: edges since reset release and the inputs seen at the last edge.
  logic [10:0] exp_out = {4'hF, 7'h7F};
  int          k = 0;
  int          cur_pos = 0;
  logic [3:0]  pv = 4'h0;
  logic        pm = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out <= {4'hF, 7'h7F};
      k       <= 0;
      cur_pos <= 0;
      pv      <= 4'h0;
      pm      <= 1'b0;
    end else begin
      exp_out <= model(pv, pm, (k / DIV) % 4);
      cur_pos <= (k / DIV) % 4;
      pv      <= dif.value;
      pm      <= dif.mode;
      k       <= k + 1;
    end
  end

  // Per-cycle comparison plus anode legality and scan-period checks.
  int cyc = 0;
  int last_onset = -1;
  logic [3:0] prev_an = 4'hF;
  always @(negedge clk) begin
    cyc++;
    checks++;
    if ({dif.an, dif.seg} !== exp_out) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: an=%b seg=%h required an=%b seg=%h",
               $time, dif.an, dif.seg, exp_out[10:7], exp_out[6:0]);
    end
    checks++;
    if ($countones(~dif.an) > 1) begin
      errors++;
      $display("FAIL an_onehot t=%0t: an=%b", $time, dif.an);
    end
    if (!rst_n) last_onset = -1;
    else if (dif.an == 4'b1110 && prev_an != 4'b1110) begin
      if (last_onset >= 0) begin
        checks++;
        if (cyc - last_onset != 16) begin
          errors++;
          $display("FAIL scan_period: %0d cycles required 16", cyc - last_onset);
        end
      end
      last_onset = cyc;
    end
    prev_an = dif.an;
  end

  task automatic drive(input logic [3:0] v, input logic m, input int n);
    @(negedge clk);
    dif.value = v;
    dif.mode  = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_slot(input logic [3:0] a, input logic [6:0] s, input string nm);
    bit hit = 0;
    for (int i = 0; i < 24 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (dif.an == a) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: an=%b never seen", nm, a);
    end else if (dif.seg !== s) begin
      errors++;
      $display("FAIL %s: seg=%h required %h", nm, dif.seg, s);
    end
  endtask

  initial begin
    bit hit;
    dif.value = 4'hF;
    dif.mode  = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    // First edge shows the reset capture (0), second edge shows F.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dif.an !== 4'b1110 || dif.seg !== 7'h0E) begin
      errors++;
      $display("FAIL reset_release: an=%b seg=%h required an=1110 seg=0e", dif.an, dif.seg);
    end

    drive(4'd0, 1'b0, 20);
    expect_slot(4'b1110, 7'h40, "dec0");
    drive(4'd9, 1'b0, 20);
    expect_slot(4'b1110, 7'h10, "dec9");
    drive(4'd3, 1'b0, 20);
    expect_slot(4'b1110, 7'h30, "dec3");
    drive(4'd12, 1'b0, 20);
    expect_slot(4'b1110, 7'h24, "dec12_ones");
    expect_slot(4'b1101, 7'h79, "dec12_tens");
    drive(4'd15, 1'b0, 20);
    expect_slot(4'b1110, 7'h12, "dec15_ones");
    expect_slot(4'b1101, 7'h79, "dec15_tens");
    drive(4'hA, 1'b1, 20);
    expect_slot(4'b1110, 7'h08, "hexA");
    drive(4'hF, 1'b1, 20);
    expect_slot(4'b1110, 7'h0E, "hexF");
    drive(4'hC, 1'b1, 20);
    expect_slot(4'b1110, 7'h46, "hexC");
    drive(4'h6, 1'b1, 20);
    expect_slot(4'b1110, 7'h02, "hex6");

    // Async reset mid-slot at position 2.
    drive(4'd12, 1'b0, 4);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (cur_pos == 2) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL find_pos2: scan position 2 never reached");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dif.an !== 4'hF || dif.seg !== 7'h7F) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%h required an=1111 seg=7f", dif.an, dif.seg);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < DIV + 2 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (dif.an == 4'b1110 && dif.seg == 7'h24) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_restart: '2' on index0 not seen within %0d clk", DIV + 2);
    end

    // Random level changes, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) dif.value = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) dif.mode = ~dif.mode;
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
